// File: rtl/sram_dual_arbiter_pkg.sv
// sram_arb_pkg: shared types and constants for the dual-port SRAM arbiter.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_CNT_WIDTH : default widths (16x32 macro)
//   READ_LATENCY : clock edges from command-register load to SRAM data capture
//   req_id_t     : which port-0 requester owns a command / read return
//   port0_cmd_t  : registered port-0 command pins {csb, web, addr, din}
package sram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int READ_LATENCY   = 2;

  typedef enum logic {
    REQ_R0 = 1'b0,
    REQ_R1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic                      csb;
    logic                      web;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] din;
  } port0_cmd_t;

  function automatic req_id_t other_req(req_id_t id);
    return (id == REQ_R0) ? REQ_R1 : REQ_R0;
  endfunction

endpackage

// File: rtl/sram_dual_arbiter_if.sv
// sram_dual_arbiter_if: requester buses (R0, R1 read/write; R2 read-only), the
// SRAM macro pins and the collision counter, bundled for the arbiter.
//   slave  : arbiter view (takes requests and sram_dout*, drives ready/rvalid/rdata and command pins)
//   master : environment view (requesters plus the SRAM macro)
// Handshake: a request transfers on a cycle where valid and ready are both high;
// ready is combinational and may be high without valid. rvalid is a one-cycle
// pulse and rdata holds its value until the next response for that requester.
interface sram_dual_arbiter_if #(
  parameter int DW = sram_arb_pkg::DEF_DATA_WIDTH,
  parameter int AW = sram_arb_pkg::DEF_ADDR_WIDTH,
  parameter int CW = sram_arb_pkg::DEF_CNT_WIDTH
);
  logic          r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata, r0_rdata;
  logic          r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata, r1_rdata;
  logic          r2_valid, r2_ready, r2_rvalid;
  logic [AW-1:0] r2_addr;
  logic [DW-1:0] r2_rdata;
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout0, sram_dout1;
  logic [CW-1:0] collide_cnt;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    input  r2_valid, r2_addr,
    output r2_ready, r2_rvalid, r2_rdata,
    output sram_csb0, sram_web0, sram_addr0, sram_din0,
    input  sram_dout0,
    output sram_csb1, sram_addr1,
    input  sram_dout1,
    output collide_cnt
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    output r2_valid, r2_addr,
    input  r2_ready, r2_rvalid, r2_rdata,
    input  sram_csb0, sram_web0, sram_addr0, sram_din0,
    output sram_dout0,
    input  sram_csb1, sram_addr1,
    output sram_dout1,
    input  collide_cnt
  );
endinterface

// File: rtl/sram_dual_arbiter_rd_pipe.sv
// sram_rd_pipe: read-return pipeline for one SRAM port.
//   clk, rst  : clock, asynchronous active-high reset (drops in-flight reads)
//   issue_i   : a read is being accepted this cycle
//   tag_i     : destination index of that read (0 when N_DEST == 1)
//   dout_i    : SRAM read data
//   rvalid_o  : per-destination one-cycle response pulse
//   rdata_o   : per-destination read data, held between responses
// Stage 0 tracks the command registers, stage 1 the SRAM sampling edge; data is
// captured on the following edge.
module sram_rd_pipe
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_DEST     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_i,
  input  logic                               tag_i,
  input  logic [DATA_WIDTH-1:0]              dout_i,
  output logic [N_DEST-1:0]                  rvalid_o,
  output logic [N_DEST-1:0][DATA_WIDTH-1:0]  rdata_o
);

  logic [READ_LATENCY-1:0]                vld_q;
  logic [READ_LATENCY-1:0]                tag_q;
  logic [N_DEST-1:0]                      rvalid_q;
  logic [N_DEST-1:0][DATA_WIDTH-1:0]      rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      tag_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      vld_q <= {vld_q[READ_LATENCY-2:0], issue_i};
      tag_q <= {tag_q[READ_LATENCY-2:0], tag_i};
      for (int d = 0; d < N_DEST; d++) begin
        rvalid_q[d] <= vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == 1'(d));
        if (vld_q[READ_LATENCY-1] && (tag_q[READ_LATENCY-1] == 1'(d))) begin
          rdata_q[d] <= dout_i;
        end
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: rtl/sram_dual_arbiter.sv
// sram_dual_arbiter: shares a 16x32 dual-port SRAM between R0/R1 (read/write,
// arbitrated onto port 0) and R2 (read-only, owns port 1). All SRAM command pins
// are registered; reads return two edges after the command registers load.
//   clk : single clock (SRAM clk0/clk1 tied to it externally)
//   rst : asynchronous, active-high reset
//   bus : sram_dual_arbiter_if.slave (requesters, SRAM pins, collide_cnt)
// Build option: define SRAM_ARB_RR_EN for round-robin between R0 and R1;
// otherwise R0 has fixed priority and no pointer register exists.
// Widths must match the interface parameters and the package defaults used by port0_cmd_t.
module sram_dual_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  sram_dual_arbiter_if.slave bus
);

  localparam port0_cmd_t CMD0_IDLE = '{csb: 1'b1, web: 1'b1, addr: '0, din: '0};

  logic                  r0_gnt, r1_gnt, p0_accept, sel_we, collide, r2_accept;
  req_id_t               sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  port0_cmd_t            cmd0_q, cmd0_d;
  logic                  csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // The grant looks only at R0/R1 so the R2 stall (which depends on the grant)
  // never feeds back into it.
`ifdef SRAM_ARB_RR_EN
  req_id_t prio_q, prio_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= REQ_R0;
    else     prio_q <= prio_d;
  end

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    prio_d = prio_q;
    if (prio_q == REQ_R0) begin
      if (bus.r0_valid)      r0_gnt = 1'b1;
      else if (bus.r1_valid) r1_gnt = 1'b1;
    end else begin
      if (bus.r1_valid)      r1_gnt = 1'b1;
      else if (bus.r0_valid) r0_gnt = 1'b1;
    end
    // After any accept, favour the requester that did not win.
    if (r0_gnt)      prio_d = other_req(REQ_R0);
    else if (r1_gnt) prio_d = other_req(REQ_R1);
  end
`else
  always_comb begin
    r0_gnt = bus.r0_valid;
    r1_gnt = bus.r1_valid & ~bus.r0_valid;
  end
`endif

  always_comb begin
    p0_accept = r0_gnt | r1_gnt;
    sel_id    = r1_gnt ? REQ_R1 : REQ_R0;
    sel_we    = (sel_id == REQ_R1) ? bus.r1_we    : bus.r0_we;
    sel_addr  = (sel_id == REQ_R1) ? bus.r1_addr  : bus.r0_addr;
    sel_wdata = (sel_id == REQ_R1) ? bus.r1_wdata : bus.r0_wdata;

    // A port-0 write and a port-1 read of one address would hit the macro on the
    // same edge; R2 yields. Port-0 reads to the same address are harmless.
    collide   = bus.r2_valid & p0_accept & sel_we & (sel_addr == bus.r2_addr);
    r2_accept = bus.r2_valid & ~collide;

    cmd0_d     = cmd0_q;
    cmd0_d.csb = 1'b1;
    cmd0_d.web = 1'b1;
    if (p0_accept) begin
      cmd0_d.csb  = 1'b0;
      cmd0_d.web  = ~sel_we;
      cmd0_d.addr = sel_addr;
      if (sel_we) cmd0_d.din = sel_wdata;
    end

    csb1_d  = ~r2_accept;
    addr1_d = r2_accept ? bus.r2_addr : addr1_q;

    cnt_d = cnt_q;
    if (collide && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd0_q  <= CMD0_IDLE;
      csb1_q  <= 1'b1;
      addr1_q <= '0;
      cnt_q   <= '0;
    end else begin
      cmd0_q  <= cmd0_d;
      csb1_q  <= csb1_d;
      addr1_q <= addr1_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [1:0]                 p0_rvalid;
  logic [1:0][DATA_WIDTH-1:0] p0_rdata;
  logic [0:0]                 p1_rvalid;
  logic [0:0][DATA_WIDTH-1:0] p1_rdata;

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .N_DEST(2)) u_rd_pipe0 (
    .clk      (clk),
    .rst      (rst),
    .issue_i  (p0_accept & ~sel_we),
    .tag_i    (sel_id == REQ_R1),
    .dout_i   (bus.sram_dout0),
    .rvalid_o (p0_rvalid),
    .rdata_o  (p0_rdata)
  );

  sram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .N_DEST(1)) u_rd_pipe1 (
    .clk      (clk),
    .rst      (rst),
    .issue_i  (r2_accept),
    .tag_i    (1'b0),
    .dout_i   (bus.sram_dout1),
    .rvalid_o (p1_rvalid),
    .rdata_o  (p1_rdata)
  );

  assign bus.r0_ready    = r0_gnt;
  assign bus.r1_ready    = r1_gnt;
  assign bus.r2_ready    = ~collide;
  assign bus.r0_rvalid   = p0_rvalid[0];
  assign bus.r0_rdata    = p0_rdata[0];
  assign bus.r1_rvalid   = p0_rvalid[1];
  assign bus.r1_rdata    = p0_rdata[1];
  assign bus.r2_rvalid   = p1_rvalid[0];
  assign bus.r2_rdata    = p1_rdata[0];
  assign bus.sram_csb0   = cmd0_q.csb;
  assign bus.sram_web0   = cmd0_q.web;
  assign bus.sram_addr0  = cmd0_q.addr;
  assign bus.sram_din0   = cmd0_q.din;
  assign bus.sram_csb1   = csb1_q;
  assign bus.sram_addr1  = addr1_q;
  assign bus.collide_cnt = cnt_q;

endmodule

// File: tb/tb_sram_dual_arbiter.sv
// tb_sram_dual_arbiter: bench for sram_dual_arbiter with a behavioural SRAM and
// a transaction-level reference model checked every cycle on the falling edge.
module tb_sram_dual_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_dual_arbiter_if #(.DW(32), .AW(4), .CW(8)) bus ();

  sram_dual_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SRAM macro ----------------
  logic [31:0] sram_mem[16];
  always @(posedge clk) begin
    if (!bus.sram_csb0 && !bus.sram_web0) sram_mem[bus.sram_addr0] <= bus.sram_din0;
    if (!bus.sram_csb0 && bus.sram_web0) bus.sram_dout0 <= sram_mem[bus.sram_addr0];
    else                                 bus.sram_dout0 <= $urandom;
    if (!bus.sram_csb1) bus.sram_dout1 <= sram_mem[bus.sram_addr1];
    else                bus.sram_dout1 <= $urandom;
  end

  // ---------------- reference model + scoreboard ----------------
  // exp_q entry: {requester id[49:48], due cycle[47:32], data[31:0]}
  logic [49:0] exp_q[$];
  logic [31:0] mem_m[16];
  logic [31:0] hold_rd[3];
  int          cyc = 0;
  logic        exp_csb0, exp_web0, exp_csb1;
  logic [3:0]  exp_addr0, exp_addr1;
  logic [31:0] exp_din0;
  int          exp_cnt;
`ifdef SRAM_ARB_RR_EN
  int          fav;
`endif

  function automatic logic [31:0] act_rdata(input int i);
    case (i)
      0:       return bus.r0_rdata;
      1:       return bus.r1_rdata;
      default: return bus.r2_rdata;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic [2:0]  exp_rv, act_rv;
    int          win;
    logic        we_s, coll;
    logic [3:0]  addr_s;
    logic [31:0] wd_s;
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_csb0 = 1'b1; exp_web0 = 1'b1; exp_csb1 = 1'b1;
      exp_addr0 = '0; exp_addr1 = '0; exp_din0 = '0; exp_cnt = 0;
      for (int i = 0; i < 3; i++) hold_rd[i] = '0;
`ifdef SRAM_ARB_RR_EN
      fav = 0;
`endif
      chk("rst_csb0", bus.sram_csb0, 1);
      chk("rst_csb1", bus.sram_csb1, 1);
      chk("rst_web0", bus.sram_web0, 1);
      chk("rst_rvalid", {bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid}, 0);
      chk("rst_cnt", bus.collide_cnt, 0);
    end else begin
      chk("csb0", bus.sram_csb0, exp_csb0);
      chk("web0", bus.sram_web0, exp_web0);
      chk("addr0", bus.sram_addr0, exp_addr0);
      chk("din0", bus.sram_din0, exp_din0);
      chk("csb1", bus.sram_csb1, exp_csb1);
      chk("addr1", bus.sram_addr1, exp_addr1);
      chk("collide_cnt", bus.collide_cnt, 64'(exp_cnt));

      exp_rv = '0;
      while (exp_q.size() > 0 && exp_q[0][47:32] == 16'(cyc)) begin
        exp_rv[exp_q[0][49:48]]  = 1'b1;
        hold_rd[exp_q[0][49:48]] = exp_q[0][31:0];
        void'(exp_q.pop_front());
      end
      act_rv = {bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("r%0d_rvalid", i), act_rv[i], exp_rv[i]);
        chk($sformatf("r%0d_rdata", i), act_rdata(i), hold_rd[i]);
      end

      // who wins port 0 this cycle
      win = -1;
`ifdef SRAM_ARB_RR_EN
      if (fav == 0) win = bus.r0_valid ? 0 : (bus.r1_valid ? 1 : -1);
      else          win = bus.r1_valid ? 1 : (bus.r0_valid ? 0 : -1);
`else
      win = bus.r0_valid ? 0 : (bus.r1_valid ? 1 : -1);
`endif
      we_s   = (win == 1) ? bus.r1_we    : bus.r0_we;
      addr_s = (win == 1) ? bus.r1_addr  : bus.r0_addr;
      wd_s   = (win == 1) ? bus.r1_wdata : bus.r0_wdata;
      coll   = bus.r2_valid && (win >= 0) && we_s && (addr_s == bus.r2_addr);
      chk("r0_ready", bus.r0_ready, (win == 0));
      chk("r1_ready", bus.r1_ready, (win == 1));
      chk("r2_ready", bus.r2_ready, !coll);

      // advance model to the next edge; R2 read before any port-0 write update
      if (bus.r2_valid && !coll) begin
        exp_csb1 = 1'b0;
        exp_addr1 = bus.r2_addr;
        exp_q.push_back({2'd2, 16'(cyc + 3), mem_m[bus.r2_addr]});
      end else begin
        exp_csb1 = 1'b1;
      end
      if (win >= 0) begin
        exp_csb0 = 1'b0;
        exp_web0 = !we_s;
        exp_addr0 = addr_s;
        if (we_s) begin
          exp_din0 = wd_s;
          mem_m[addr_s] = wd_s;
        end else begin
          exp_q.push_back({2'(win), 16'(cyc + 3), mem_m[addr_s]});
        end
`ifdef SRAM_ARB_RR_EN
        fav = 1 - win;
`endif
      end else begin
        exp_csb0 = 1'b1;
        exp_web0 = 1'b1;
      end
      if (coll && exp_cnt < 255) exp_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.r0_valid = 0; bus.r0_we = 0; bus.r0_addr = '0; bus.r0_wdata = '0;
    bus.r1_valid = 0; bus.r1_we = 0; bus.r1_addr = '0; bus.r1_wdata = '0;
    bus.r2_valid = 0; bus.r2_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         k, r0_cnt;
    logic       got, pulse;
    logic [5:0] pat;
    idle_inputs();
    bus.sram_dout0 = '0;
    bus.sram_dout1 = '0;
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = '0;
      mem_m[i]    = '0;
    end
    repeat (3) step();
    rst = 1'b0;

    // reset then idle for 10 cycles
    repeat (10) begin
      @(negedge clk);
      chk("idle_csb0", bus.sram_csb0, 1);
      chk("idle_csb1", bus.sram_csb1, 1);
      chk("idle_web0", bus.sram_web0, 1);
      chk("idle_rvalid", {bus.r2_rvalid, bus.r1_rvalid, bus.r0_rvalid}, 0);
      chk("idle_cnt", bus.collide_cnt, 0);
    end
    step();

    // R0 writes 0xDEADBEEF to addr 3, R1 reads it back
    do_reset();
    bus.r0_valid = 1; bus.r0_we = 1; bus.r0_addr = 4'd3; bus.r0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_r0_ready", bus.r0_ready, 1);
    step();
    bus.r0_valid = 0;
    bus.r1_valid = 1; bus.r1_we = 0; bus.r1_addr = 4'd3;
    @(negedge clk);
    chk("rd_r1_ready", bus.r1_ready, 1);
    step();
    bus.r1_valid = 0;
    k = 0; got = 0; pulse = 0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (bus.r0_rvalid) pulse = 1;
      if (bus.r1_rvalid) begin
        got = 1;
        k = i;
        chk("rd_r1_data", bus.r1_rdata, 32'hDEADBEEF);
      end
    end
    chk("rd_r1_latency", 64'(k), 3);
    chk("rd_r0_quiet", pulse, 0);
    step();

    // R0 and R1 both request for 6 cycles
    do_reset();
    bus.r0_valid = 1; bus.r0_we = 0; bus.r0_addr = 4'd0;
    bus.r1_valid = 1; bus.r1_we = 0; bus.r1_addr = 4'd1;
    pat = '0; r0_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i] = bus.r1_ready;
      if (bus.r0_ready) r0_cnt++;
      step();
    end
    idle_inputs();
`ifdef SRAM_ARB_RR_EN
    chk("rr_pattern", pat, 6'b101010);
    chk("rr_r0_grants", 64'(r0_cnt), 3);
`else
    chk("fixed_pattern", pat, 6'b000000);
    chk("fixed_r0_grants", 64'(r0_cnt), 6);
`endif
    repeat (4) step();

    // R0 write and R2 read to addr 5 in the same cycle
    do_reset();
    bus.r0_valid = 1; bus.r0_we = 1; bus.r0_addr = 4'd5; bus.r0_wdata = 32'h5555AAAA;
    bus.r2_valid = 1; bus.r2_addr = 4'd5;
    @(negedge clk);
    chk("coll_r0_ready", bus.r0_ready, 1);
    chk("coll_r2_ready", bus.r2_ready, 0);
    step();
    bus.r0_valid = 0;
    @(negedge clk);
    chk("coll_cnt_one", bus.collide_cnt, 1);
    chk("coll_r2_retry_ready", bus.r2_ready, 1);
    step();
    bus.r2_valid = 0;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.r2_rvalid) begin
        got = 1;
        chk("coll_r2_data", bus.r2_rdata, 32'h5555AAAA);
      end
    end
    chk("coll_r2_response", got, 1);
    step();

    // 300 collisions saturate the counter
    do_reset();
    bus.r0_valid = 1; bus.r0_we = 1; bus.r0_addr = 4'd7; bus.r0_wdata = 32'h0BADF00D;
    bus.r2_valid = 1; bus.r2_addr = 4'd7;
    repeat (300) step();
    idle_inputs();
    @(negedge clk);
    chk("cnt_saturated", bus.collide_cnt, 255);
    step();

    // reset one cycle after R1/R2 read accepts: no response may appear
    do_reset();
    bus.r1_valid = 1; bus.r1_we = 0; bus.r1_addr = 4'd2;
    bus.r2_valid = 1; bus.r2_addr = 4'd9;
    @(negedge clk);
    chk("mid_r1_ready", bus.r1_ready, 1);
    chk("mid_r2_ready", bus.r2_ready, 1);
    step();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_csb0", bus.sram_csb0, 1);
    chk("mid_async_csb1", bus.sram_csb1, 1);
    step();
    rst = 1'b0;
    pulse = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.r0_rvalid || bus.r1_rvalid || bus.r2_rvalid) pulse = 1;
    end
    chk("mid_no_rvalid", pulse, 0);
    step();

    // randomized traffic on all three requesters, narrow address range
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      bus.r0_valid = ($urandom_range(0, 9) < 6);
      bus.r0_we    = 1'($urandom_range(0, 1));
      bus.r0_addr  = 4'($urandom_range(0, 3));
      bus.r0_wdata = $urandom;
      bus.r1_valid = ($urandom_range(0, 9) < 6);
      bus.r1_we    = 1'($urandom_range(0, 1));
      bus.r1_addr  = 4'($urandom_range(0, 3));
      bus.r1_wdata = $urandom;
      bus.r2_valid = ($urandom_range(0, 9) < 7);
      bus.r2_addr  = 4'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    repeat (6) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
